// File: rtl/gate2_vector_engine.sv
// ---------------------------------------------------------------------------
// gate2_vector_engine
//
// Self-timed stimulus generator and checker for a single 2-input gate.
// When a run is accepted, the engine walks the four input vectors 00, 01,
// 10 and 11 onto the gate inputs. It holds each vector for SETTLE_CYCLES
// clocks, samples the gate output and compares it against a latched
// 4-bit truth table. At the end it reports:
//   - how many vectors mismatched,
//   - which vector failed first,
//   - an overall pass flag.
//
// Parameters
//   SETTLE_CYCLES     clocks each vector is held before sampling (1..255)
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   start             run request, honoured only when idle or done
//   truth_table[3:0]  expected gate output, bit index = {i1,i2}
//   dut_o             output of the gate under test
//   i1, i2            registered gate inputs (vector bit 1 / bit 0)
//   busy              run in progress
//   done              run complete, held until the next accepted start
//   pass              done with no mismatches
//   err_count[2:0]    number of mismatching vectors (0..4)
//   first_fail_valid  at least one mismatch recorded this run
//   first_fail_vec    {i1,i2} of the first mismatch, 00 when not valid
// ---------------------------------------------------------------------------
module gate2_vector_engine #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] truth_table,
    input  logic       dut_o,
    output logic       i1,
    output logic       i2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic       first_fail_valid,
    output logic [1:0] first_fail_vec
);

    // The settle counter only has to reach SETTLE_CYCLES-1.
    // It is kept at least one bit wide so that SETTLE_CYCLES=1 still
    // elaborates; in that case the counter simply stays at zero.
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]  tt_q, tt_d;
    logic        i1_q, i1_d;
    logic        i2_q, i2_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  err_count_q, err_count_d;
    logic        ff_valid_q, ff_valid_d;
    logic [1:0]  ff_vec_q, ff_vec_d;

    logic        expected_o;
    logic        mismatch;
    logic [1:0]  vec_next;

    // State and output registers. Every output except pass comes straight
    // from one of these flops, so the gate inputs are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_q       <= 2'd0;
            cnt_q       <= '0;
            tt_q        <= 4'd0;
            i1_q        <= 1'b0;
            i2_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_count_q <= 3'd0;
            ff_valid_q  <= 1'b0;
            ff_vec_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            tt_q        <= tt_d;
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_count_q <= err_count_d;
            ff_valid_q  <= ff_valid_d;
            ff_vec_q    <= ff_vec_d;
        end
    end

    // Sequencer: next-state logic and the register updates for the
    // sample and compare step.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        tt_d        = tt_q;
        i1_d        = i1_q;
        i2_d        = i2_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_count_d = err_count_q;
        ff_valid_d  = ff_valid_q;
        ff_vec_d    = ff_vec_q;

        expected_o = tt_q[vec_q];
        vec_next   = vec_q + 2'd1;

        // The mismatch flag defaults to 1 and is cleared only on a
        // positive equality. In simulation, an X or Z on dut_o makes the
        // equality unknown, so the clear is skipped and the vector counts
        // as failing.
        mismatch = 1'b1;
        if (dut_o == expected_o) begin
            mismatch = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    vec_d       = 2'd0;
                    cnt_d       = '0;
                    tt_d        = truth_table;
                    i1_d        = 1'b0;
                    i2_d        = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    err_count_d = 3'd0;
                    ff_valid_d  = 1'b0;
                    ff_vec_d    = 2'd0;
                end
            end

            ST_RUN: begin
                // start and truth_table are deliberately ignored here.
                // Only the copy latched in tt_q is used for the compare.
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    // At most four vectors are checked, so the 3-bit error
                    // count tops out at 4 and can never wrap.
                    if (mismatch) begin
                        err_count_d = err_count_q + 3'd1;
                        if (!ff_valid_q) begin
                            ff_valid_d = 1'b1;
                            ff_vec_d   = vec_q;
                        end
                    end

                    // The edge that samples vector k also drives vector k+1.
                    if (vec_q != 2'd3) begin
                        vec_d = vec_next;
                        i1_d  = vec_next[1];
                        i2_d  = vec_next[0];
                        cnt_d = '0;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        i1_d    = 1'b0;
                        i2_d    = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign i1               = i1_q;
    assign i2               = i2_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err_count        = err_count_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_vec   = ff_vec_q;

    // pass is the only combinational output: a single AND of two
    // registered terms.
    assign pass = done_q & (err_count_q == 3'd0);

endmodule

// File: tb/tb_gate2_vector_engine.sv
// ---------------------------------------------------------------------------
// tb_gate2_vector_engine
//
// Directed bench for gate2_vector_engine. Instance A (SETTLE_CYCLES=4)
// is used for these single runs:
//   - AND pass,
//   - wrong truth table,
//   - stuck-at output,
//   - ignored mid-run inputs,
//   - reset mid-run.
// Instance B (SETTLE_CYCLES=1) runs back-to-back with start held high.
//
// Expected results are pushed into scoreboard queues when a run is issued.
// Monitor processes pop and compare them when done rises, and also follow
// the vector sequence cycle by cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gate2_vector_engine;

    localparam int S_A       = 4;
    localparam int S_B       = 1;
    localparam int MODE_AND  = 0;
    localparam int MODE_ONE  = 1;
    localparam int MODE_ZERO = 2;

    typedef struct {
        int err;
        int ffv;
        int ffvec;
        int pass_exp;
        int cycle;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start;
    logic [3:0] truth_table;
    logic       dut_o;
    logic       i1;
    logic       i2;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic       ffv;
    logic [1:0] ffvec;

    logic       start_b;
    logic       dut_o_b;
    logic       i1_b;
    logic       i2_b;
    logic       busy_b;
    logic       done_b;
    logic       pass_b;
    logic [2:0] err_b;
    logic       ffv_b;
    logic [1:0] ffvec_b;

    int   mode = MODE_AND;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accept_a = 0;
    int   acc_b = 0;
    bit   mon_a = 1'b0;
    bit   mon_b = 1'b0;
    logic done_prev_a = 1'b0;
    logic done_prev_b = 1'b0;
    exp_t sb[$];
    int   qb[$];
    exp_t mon_e;
    int   kb;
    int   cb;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Gate models: an AND gate, or a stuck-at-1 / stuck-at-0 output.
    assign dut_o   = (mode == MODE_AND) ? (i1 & i2) : (mode == MODE_ONE);
    assign dut_o_b = i1_b & i2_b;

    gate2_vector_engine #(.SETTLE_CYCLES(S_A)) u_dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .truth_table      (truth_table),
        .dut_o            (dut_o),
        .i1               (i1),
        .i2               (i2),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_valid (ffv),
        .first_fail_vec   (ffvec)
    );

    gate2_vector_engine #(.SETTLE_CYCLES(S_B)) u_dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_b),
        .truth_table      (4'b1000),
        .dut_o            (dut_o_b),
        .i1               (i1_b),
        .i2               (i2_b),
        .busy             (busy_b),
        .done             (done_b),
        .pass             (pass_b),
        .err_count        (err_b),
        .first_fail_valid (ffv_b),
        .first_fail_vec   (ffvec_b)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for instance A. It checks the driven vector on every cycle
    // of a run, and checks the final results on the rising edge of done.
    always @(negedge clk) begin
        if (rst_n && mon_a) begin
            if (busy) begin
                checkOutput("a_vector", int'({i1, i2}), ((cyc - accept_a) / S_A) % 4);
            end
            if (done && !done_prev_a) begin
                if (sb.size() == 0) begin
                    checkOutput("a_unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("a_done_cycle", cyc, mon_e.cycle);
                    checkOutput("a_busy_at_done", int'(busy), 0);
                    checkOutput("a_err_count", int'(err_count), mon_e.err);
                    checkOutput("a_first_fail_valid", int'(ffv), mon_e.ffv);
                    checkOutput("a_first_fail_vec", int'(ffvec), mon_e.ffvec);
                    checkOutput("a_pass", int'(pass), mon_e.pass_exp);
                    checkOutput("a_ii_idle", int'({i1, i2}), 0);
                end
            end
        end
        done_prev_a = done;
    end

    // Monitor for instance B. With S=1 and start held high, each run lasts
    // five cycles: four busy cycles, one per vector, then one done cycle.
    always @(negedge clk) begin
        if (rst_n && mon_b) begin
            kb = cyc - acc_b;
            if (kb >= 0 && kb < 15) begin
                checkOutput("b_busy", int'(busy_b), int'((kb % 5) < 4));
                if ((kb % 5) < 4) begin
                    checkOutput("b_vector", int'({i1_b, i2_b}), kb % 5);
                end
            end
            if (done_b && !done_prev_b) begin
                if (qb.size() == 0) begin
                    checkOutput("b_unexpected_done", 1, 0);
                end else begin
                    cb = qb.pop_front();
                    checkOutput("b_done_cycle", cyc, cb);
                    checkOutput("b_pass", int'(pass_b), 1);
                    checkOutput("b_err_count", int'(err_b), 0);
                end
            end
        end
        done_prev_b = done_b;
    end

    task automatic waitDone();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checkOutput("a_run_timeout", int'(done), 1);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] tt, input int m, input int e_err,
                                 input int e_ffv, input int e_ffvec, input int e_pass,
                                 input bit poke_midrun);
        exp_t e;
        @(negedge clk);
        mode        = m;
        truth_table = tt;
        start       = 1'b1;
        accept_a    = cyc + 1;
        mon_a       = 1'b1;
        e.err       = e_err;
        e.ffv       = e_ffv;
        e.ffvec     = e_ffvec;
        e.pass_exp  = e_pass;
        e.cycle     = accept_a + 4 * S_A;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (poke_midrun) begin
            repeat (5) @(negedge clk);
            start       = 1'b1;
            truth_table = 4'b0000;
            @(negedge clk);
            start = 1'b0;
        end
        waitDone();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at t=%0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        start_b     = 1'b0;
        truth_table = 4'b0000;
        repeat (2) @(negedge clk);

        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_pass", int'(pass), 0);
        checkOutput("rst_err_count", int'(err_count), 0);
        checkOutput("rst_ii", int'({i1, i2}), 0);
        checkOutput("rst_b_done", int'(done_b), 0);
        rst_n = 1'b1;

        // AND gate checked against the AND table.
        applyStimulus(4'b1000, MODE_AND, 0, 0, 0, 1, 1'b0);
        // AND gate checked against the OR table: vectors 01 and 10 fail.
        applyStimulus(4'b1110, MODE_AND, 2, 1, 1, 0, 1'b0);
        // Stuck-at-1 output: vectors 00, 01 and 10 fail.
        applyStimulus(4'b1000, MODE_ONE, 3, 1, 0, 0, 1'b0);
        // Stuck-at-0 output, restarting from DONE: only vector 11 fails.
        applyStimulus(4'b1000, MODE_ZERO, 1, 1, 3, 0, 1'b0);
        // start and a zeroed truth_table arrive mid-run; both must be ignored.
        applyStimulus(4'b1000, MODE_AND, 0, 0, 0, 1, 1'b1);

        // Reset mid-run while vector 2 is applied. The gate is stuck at 1,
        // so two errors have already been counted when reset arrives.
        @(negedge clk);
        mode        = MODE_ONE;
        truth_table = 4'b1000;
        start       = 1'b1;
        accept_a    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < accept_a + 9) @(negedge clk);
        checkOutput("pre_rst_err_count", int'(err_count), 2);
        checkOutput("pre_rst_ff_valid", int'(ffv), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ii", int'({i1, i2}), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_done", int'(done), 0);
        checkOutput("midrst_pass", int'(pass), 0);
        checkOutput("midrst_err_count", int'(err_count), 0);
        checkOutput("midrst_ff_valid", int'(ffv), 0);
        checkOutput("midrst_ff_vec", int'(ffvec), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1000, MODE_AND, 0, 0, 0, 1, 1'b0);

        // Back-to-back runs on the S=1 instance with start held high.
        @(negedge clk);
        start_b = 1'b1;
        acc_b   = cyc + 1;
        mon_b   = 1'b1;
        qb.push_back(acc_b + 4);
        qb.push_back(acc_b + 9);
        qb.push_back(acc_b + 14);
        while (cyc < acc_b + 10) @(negedge clk);
        start_b = 1'b0;
        while (cyc < acc_b + 16) @(negedge clk);
        mon_b = 1'b0;
        checkOutput("b_runs_outstanding", qb.size(), 0);

        @(negedge clk);
        checkOutput("a_runs_outstanding", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate2_vector_engine.md
# gate2_vector_engine

Self-timed stimulus/checker for one 2-input gate (AND2, OR2 and later 2-input primitives). On `start` it drives all four input combinations into the gate under test, waits a programmable settle time, samples the gate output, and compares it against a 4-bit expected truth table. It sits directly upstream of the gate inputs and downstream of its output, replacing hand-written per-gate directed stimulus with one synthesizable, reusable sequencer. It reports an error count, the first failing vector and a pass flag.

## Interface
- `SETTLE_CYCLES`, default 4: clock cycles each vector is held before `dut_o` is sampled. Legal range 1..255.
- `clk` input 1: rising-edge clock; single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a run; sampled only in IDLE or DONE.
- `truth_table` input 4: expected gate output, indexed by vector `{i1,i2}`. Bit 0 is expected `o` for 00; bit 3 for 11. Latched when `start` is accepted.
- `dut_o` input 1: output of the gate under test.
- `i1` output 1: gate input 1, registered; equals vector bit 1.
- `i2` output 1: gate input 2, registered; equals vector bit 0.
- `busy` output 1: run in progress.
- `done` output 1: run complete; sticky until next accepted `start`.
- `pass` output 1: `done` and `err_count == 0`.
- `err_count` output 3: number of mismatching vectors, 0..4.
- `first_fail_valid` output 1: at least one mismatch recorded this run.
- `first_fail_vec` output 2: `{i1,i2}` of the first mismatch; 00 when not valid.

## Operation
- **States:** IDLE, RUN, DONE. Internal signals:
  - 2-bit vector index `vec`.
  - Settle counter `cnt`, wide enough for `SETTLE_CYCLES-1`.
  - Latched table `tt`.
- **IDLE/DONE + `start`=1 at an edge:**
  - Go to RUN and set `vec`=0, `cnt`=0, `tt`=`truth_table`.
  - Clear `err_count`, `first_fail_*`, `done` and `pass`.
  - Set `i1`=0, `i2`=0 and `busy`=1.
- **RUN, each edge:**
  - If `cnt` < `SETTLE_CYCLES-1`: increment `cnt`.
  - Otherwise sample `dut_o`:
    - Mismatch means `dut_o != tt[vec]`.
    - On mismatch, increment `err_count`. If `first_fail_valid`=0, set it to 1 and set `first_fail_vec`=`vec`.
    - If `vec` < 3: increment `vec`, drive the new vector on `i1`/`i2`, and set `cnt`=0.
    - If `vec` = 3: go to DONE with `busy`=0, `done`=1, `i1`=`i2`=0.
- **`pass`:** combinational, `done & (err_count==0)`.
- **`start` while RUN:** ignored. A `start` held high continuously restarts the run at the edge after each DONE entry.
- **`truth_table` changes during RUN:** ignored; only `tt` is used.
- **`dut_o` is X/Z at the sample edge:** counted as a mismatch.
- **Reset (any time, including mid-run):** state IDLE, `vec`=0, `cnt`=0, `tt`=0, `i1`=`i2`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_valid`=0, `first_fail_vec`=00. The first `start` after `rst_n` rises begins a fresh run.
- **`err_count` saturation:** cannot wrap; 4 vectors maximum and the counter is 3 bits.

## Timing
- Let T0 be the edge that accepts `start`.
  - Vector k (k=0..3) is driven from edge T0+k·S through T0+(k+1)·S, where S=`SETTLE_CYCLES`.
  - Vector k is sampled at edge T0+(k+1)·S. That same edge drives vector k+1.
- `busy` is high from T0 to T0+4·S.
- `done`, `err_count` and `first_fail_*` are final and valid from edge T0+4·S.
- Total run latency is 4·S cycles. Restart is possible at edge T0+4·S+1 at the earliest.
- `dut_o` must be stable for at least one clock before each sample edge. The sample uses the value present at that edge, not a registered copy.
- All outputs except `pass` are registered. `pass` is one AND gate from registers.

## Test plan
- **AND pass:**
  - Setup: S=4, `truth_table`=4'b1000, `dut_o`=i1&i2.
  - Pulse `start` at T0. Vectors 00,01,10,11 appear at T0, T0+4, T0+8, T0+12.
  - At T0+16: `done`=1, `pass`=1, `err_count`=0, `first_fail_valid`=0.
- **Wrong table:**
  - Setup: `truth_table`=4'b1110 (OR), `dut_o`=i1&i2.
  - At completion: `err_count`=2, `first_fail_vec`=01, `first_fail_valid`=1, `pass`=0.
- **Stuck-at-1:**
  - Setup: `dut_o`=1, table 4'b1000.
  - At completion: `err_count`=3, `first_fail_vec`=00. Then set `dut_o`=0 and restart: `err_count`=1, `first_fail_vec`=11.
- **Ignored inputs mid-run:**
  - Pulse `start` again and flip `truth_table` to 4'b0000 during RUN.
  - Required: no restart and no change in sequencing; result matches the original table.
- **Reset mid-run:**
  - Assert `rst_n`=0 asynchronously while on vector 2, between edges.
  - Required: all outputs go to reset values immediately, before the next edge.
  - After release, a new `start` yields a clean full run with correct results.
- **S=1 back-to-back:**
  - Setup: `SETTLE_CYCLES`=1, `start` tied high, AND DUT and table.
  - Required: a new vector every cycle, `done` at T0+4, the next run accepted at T0+5, `pass`=1 every run.
